mesh_edge_fifo: RTL and testbench

//  Multi-channel terminal-side injection FIFO bank for the mesh router (mesh_gnrtr) edge ports.
//  One independent show-ahead FIFO per edge terminal (NCH = 2*ROWS+2*COLUMS).

---
 rtl/mesh_edge_pkg.sv | 35 +++
 rtl/edge_fifo_ch.sv | 107 ++++++++++
 rtl/mesh_edge_fifo.sv | 60 ++++++
 tb/tb_mesh_edge_fifo.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mesh_edge_pkg.sv
// Shared header layout and helpers for the mesh router edge FIFO bank.
// The optional MESH_EDGE_FIFO_STATS_EN build adds per-channel push statistics.
package mesh_edge_pkg;

    localparam int PCKG_SZ_DEF = 40;

    localparam int JUMP_W = 8;
    localparam int ROW_W  = 4;
    localparam int COL_W  = 4;
    localparam int MODE_W = 1;
    localparam int HDR_W  = JUMP_W + ROW_W + COL_W + MODE_W;

    // Header fields are packed from the MSB down: nxt_jump, row, col, mode
    localparam int JUMP_MSB = PCKG_SZ_DEF - 1;
    localparam int ROW_MSB  = JUMP_MSB - JUMP_W;
    localparam int COL_MSB  = ROW_MSB - ROW_W;
    localparam int MODE_MSB = COL_MSB - COL_W;

    localparam logic [PCKG_SZ_DEF-18-1:0] BDCST = {(PCKG_SZ_DEF-18){1'b1}};

    typedef enum logic {
        OVF_REJECT      = 1'b0,
        OVF_DROP_OLDEST = 1'b1
    } ovf_policy_e;

    function automatic logic [HDR_W-1:0] mk_hdr(
        input logic [JUMP_W-1:0] jump,
        input logic [ROW_W-1:0]  row,
        input logic [COL_W-1:0]  col,
        input logic [MODE_W-1:0] mode
    );
        return {jump, row, col, mode};
    endfunction

endpackage

// File: rtl/edge_fifo_ch.sv
// One show-ahead FIFO channel: storage, wrapping pointers, occupancy and sticky flags.
// With MESH_EDGE_FIFO_STATS_EN defined it also keeps accepted/dropped push counters.
module edge_fifo_ch
    import mesh_edge_pkg::*;
#(
    parameter int W           = PCKG_SZ_DEF,
    parameter int DEPTH       = 4,
    parameter int AF_LEVEL    = 3,
    parameter int DROP_OLDEST = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [W-1:0]                 din,
    input  logic                         pop,
    output logic                         full,
    output logic                         almost_full,
    output logic                         pndng,
    output logic [W-1:0]                 data_out,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         ovf,
    output logic                         udf
`ifdef MESH_EDGE_FIFO_STATS_EN
    ,
    output logic [31:0]                  accepted_cnt,
    output logic [15:0]                  dropped_cnt
`endif
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [PW-1:0] LAST    = PW'(DEPTH-1);
    localparam ovf_policy_e   POLICY  = (DROP_OLDEST != 0) ? OVF_DROP_OLDEST : OVF_REJECT;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] cnt;
    logic          empty, is_full, overflow_evt, underflow_evt;
    logic          do_write, do_pop, advance_rd;

    // Explicit compare keeps the wrap correct for non-power-of-two depths
    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        empty         = (cnt == '0);
        is_full       = (cnt == DEPTH_C);
        overflow_evt  = push && !pop && is_full;
        underflow_evt = pop && !push && empty;
        do_pop        = pop && !empty;
        do_write      = push && (!overflow_evt || (POLICY == OVF_DROP_OLDEST));
        advance_rd    = do_pop || (overflow_evt && (POLICY == OVF_DROP_OLDEST));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else begin
            if (do_write)
                wr_ptr <= bump(wr_ptr);
            if (advance_rd)
                rd_ptr <= bump(rd_ptr);
            if (do_write && !advance_rd)
                cnt <= cnt + 1'b1;
            else if (advance_rd && !do_write)
                cnt <= cnt - 1'b1;
            if (overflow_evt)
                ovf <= 1'b1;
            if (underflow_evt)
                udf <= 1'b1;
        end
    end

    // Storage is deliberately left out of reset; the pointers alone define validity
    always_ff @(posedge clk) begin
        if (do_write)
            mem[wr_ptr] <= din;
    end

    assign full        = is_full;
    assign almost_full = (cnt >= AF_C);
    assign pndng       = !empty;
    assign data_out    = empty ? '0 : mem[rd_ptr];
    assign count       = cnt;

`ifdef MESH_EDGE_FIFO_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            accepted_cnt <= '0;
            dropped_cnt  <= '0;
        end else begin
            if (do_write)
                accepted_cnt <= accepted_cnt + 32'd1;
            if (overflow_evt && (dropped_cnt != 16'hFFFF))
                dropped_cnt <= dropped_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: rtl/mesh_edge_fifo.sv
// Bank of NCH independent injection FIFOs feeding the mesh router edge ports.
// Define MESH_EDGE_FIFO_STATS_EN to expose per-channel accepted/dropped counters.
module mesh_edge_fifo
    import mesh_edge_pkg::*;
#(
    parameter int PCKG_SZ     = PCKG_SZ_DEF,
    parameter int DEPTH       = 4,
    parameter int NCH         = 16,
    parameter int AF_LEVEL    = 3,
    parameter int DROP_OLDEST = 0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NCH-1:0]                   push,
    input  logic [NCH*PCKG_SZ-1:0]           din,
    output logic [NCH-1:0]                   full,
    output logic [NCH-1:0]                   almost_full,
    output logic [NCH-1:0]                   pndng,
    output logic [NCH*PCKG_SZ-1:0]           data_out,
    input  logic [NCH-1:0]                   pop,
    output logic [NCH*$clog2(DEPTH+1)-1:0]   count,
    output logic [NCH-1:0]                   ovf,
    output logic [NCH-1:0]                   udf
`ifdef MESH_EDGE_FIFO_STATS_EN
    ,
    output logic [NCH*32-1:0]                accepted_cnt,
    output logic [NCH*16-1:0]                dropped_cnt
`endif
);

    localparam int CW = $clog2(DEPTH+1);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        edge_fifo_ch #(
            .W           (PCKG_SZ),
            .DEPTH       (DEPTH),
            .AF_LEVEL    (AF_LEVEL),
            .DROP_OLDEST (DROP_OLDEST)
        ) u_ch (
            .clk          (clk),
            .reset        (reset),
            .push         (push[i]),
            .din          (din[i*PCKG_SZ +: PCKG_SZ]),
            .pop          (pop[i]),
            .full         (full[i]),
            .almost_full  (almost_full[i]),
            .pndng        (pndng[i]),
            .data_out     (data_out[i*PCKG_SZ +: PCKG_SZ]),
            .count        (count[i*CW +: CW]),
            .ovf          (ovf[i]),
            .udf          (udf[i])
`ifdef MESH_EDGE_FIFO_STATS_EN
            ,
            .accepted_cnt (accepted_cnt[i*32 +: 32]),
            .dropped_cnt  (dropped_cnt[i*16 +: 16])
`endif
        );
    end

endmodule

// File: tb/tb_mesh_edge_fifo.sv
// Directed bench for mesh_edge_fifo: a reject-policy bank and a drop-oldest bank
// checked against per-channel expected-data queues.
module tb_mesh_edge_fifo;

    localparam int W     = 40;
    localparam int DEPTH = 4;
    localparam int NCH   = 16;
    localparam int CW    = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [NCH-1:0]    push_a, pop_a, full_a, af_a, pndng_a, ovf_a, udf_a;
    logic [NCH*W-1:0]  din_a, dout_a;
    logic [NCH*CW-1:0] cnt_a;
    logic [NCH-1:0]    push_b, pop_b, full_b, af_b, pndng_b, ovf_b, udf_b;
    logic [NCH*W-1:0]  din_b, dout_b;
    logic [NCH*CW-1:0] cnt_b;
`ifdef MESH_EDGE_FIFO_STATS_EN
    logic [NCH*32-1:0] acc_a, acc_b;
    logic [NCH*16-1:0] drp_a, drp_b;
`endif

    mesh_edge_fifo #(.PCKG_SZ(W), .DEPTH(DEPTH), .NCH(NCH), .AF_LEVEL(3), .DROP_OLDEST(0)) dut_a (
        .clk(clk), .reset(reset), .push(push_a), .din(din_a), .full(full_a),
        .almost_full(af_a), .pndng(pndng_a), .data_out(dout_a), .pop(pop_a),
        .count(cnt_a), .ovf(ovf_a), .udf(udf_a)
`ifdef MESH_EDGE_FIFO_STATS_EN
        , .accepted_cnt(acc_a), .dropped_cnt(drp_a)
`endif
    );

    mesh_edge_fifo #(.PCKG_SZ(W), .DEPTH(DEPTH), .NCH(NCH), .AF_LEVEL(3), .DROP_OLDEST(1)) dut_b (
        .clk(clk), .reset(reset), .push(push_b), .din(din_b), .full(full_b),
        .almost_full(af_b), .pndng(pndng_b), .data_out(dout_b), .pop(pop_b),
        .count(cnt_b), .ovf(ovf_b), .udf(udf_b)
`ifdef MESH_EDGE_FIFO_STATS_EN
        , .accepted_cnt(acc_b), .dropped_cnt(drp_b)
`endif
    );

    logic [W-1:0] sb [2][NCH][$];
    int total  = 0;
    int passed = 0;
    int failed = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Head, pending flag and occupancy of one channel against its queue
    task automatic check_output(input bit b, input int ch, input string tag);
        int           n;
        logic [W-1:0] exp_d;
        n     = sb[b][ch].size();
        exp_d = (n > 0) ? sb[b][ch][0] : '0;
        check({tag, "_pndng"}, 64'(b ? pndng_b[ch] : pndng_a[ch]), 64'(n > 0));
        check({tag, "_data"}, 64'(b ? dout_b[ch*W +: W] : dout_a[ch*W +: W]), 64'(exp_d));
        check({tag, "_count"}, 64'(b ? cnt_b[ch*CW +: CW] : cnt_a[ch*CW +: CW]), 64'(n));
    endtask

    // Drive one cycle on one channel, then advance the reference queue
    task automatic apply_stimulus(input bit b, input int ch, input bit p, input bit q, input logic [W-1:0] d);
        int n;
        if (b) begin
            push_b[ch] = p; pop_b[ch] = q; din_b[ch*W +: W] = d;
        end else begin
            push_a[ch] = p; pop_a[ch] = q; din_a[ch*W +: W] = d;
        end
        @(posedge clk);
        #1;
        if (b) begin
            push_b[ch] = 1'b0; pop_b[ch] = 1'b0;
        end else begin
            push_a[ch] = 1'b0; pop_a[ch] = 1'b0;
        end
        n = sb[b][ch].size();
        if (p && q && n > 0) begin
            void'(sb[b][ch].pop_front());
            sb[b][ch].push_back(d);
        end else if (p && q) begin
            sb[b][ch].push_back(d);
        end else if (q && n > 0) begin
            void'(sb[b][ch].pop_front());
        end else if (p && n < DEPTH) begin
            sb[b][ch].push_back(d);
        end else if (p && b) begin
            void'(sb[b][ch].pop_front());
            sb[b][ch].push_back(d);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        reset  = 1'b0;
        push_a = '1; pop_a = '0; din_a = {NCH{40'hDE_AD00_BEEF}};
        push_b = '0; pop_b = '0; din_b = '0;

        // T1: reset holds everything empty even with pushes asserted
        repeat (2) @(posedge clk);
        #1;
        check("t1_pndng", 64'(pndng_a), 64'(0));
        check("t1_count", 64'(cnt_a), 64'(0));
        check("t1_dout", 64'(|dout_a), 64'(0));
        check("t1_full", 64'(full_a | af_a), 64'(0));
        push_a = '0;
        reset  = 1'b1;
        @(posedge clk);
        #1;
        apply_stimulus(0, 0, 1, 0, W'(40'h11));
        check_output(0, 0, "t1_push");
        apply_stimulus(0, 0, 0, 1, '0);
        check_output(0, 0, "t1_pop");

        // T2: fill ch3, fifth push rejected
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(0, 3, 1, 0, W'(40'hA1 + i));
            check_output(0, 3, "t2_fill");
            check("t2_af", 64'(af_a[3]), 64'(i >= 2));
            check("t2_full", 64'(full_a[3]), 64'(i >= 3));
            check("t2_ovf", 64'(ovf_a[3]), 64'(i == 4));
        end
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(0, 3, 0, 1, '0);
            check_output(0, 3, "t2_drain");
        end

        // T3: drop-oldest bank keeps the newest four
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1, 0, 1, 0, W'(40'hB1 + i));
            check_output(1, 0, "t3_fill");
            check("t3_ovf", 64'(ovf_b[0]), 64'(i == 4));
        end
        check("t3_head", 64'(dout_b[W-1:0]), 64'(40'hB2));
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1, 0, 0, 1, '0);
            check_output(1, 0, "t3_drain");
        end

        // T4: simultaneous push and pop on a full channel
        for (int i = 0; i < 4; i++)
            apply_stimulus(0, 5, 1, 0, W'(40'h50 + i));
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(0, 5, 1, 1, W'(40'hC0 + i));
            check_output(0, 5, "t4_simul");
            check("t4_ovf", 64'(ovf_a[5]), 64'(0));
        end
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(0, 5, 0, 1, '0);
            check_output(0, 5, "t4_drain");
        end

        // T5: underflow on empty, push+pop on empty is a plain push
        apply_stimulus(0, 7, 0, 1, '0);
        check("t5_udf7", 64'(udf_a[7]), 64'(1));
        check_output(0, 7, "t5_empty");
        apply_stimulus(0, 8, 1, 1, W'(40'hE8));
        check("t5_udf8", 64'(udf_a[8]), 64'(0));
        check_output(0, 8, "t5_pp");

        // T6: over-push ch2, then an asynchronous mid-run reset
        for (int i = 0; i < 6; i++)
            apply_stimulus(0, 2, 1, 0, W'(40'hF0 + i));
        check_output(0, 2, "t6_full");
        check("t6_ovf", 64'(ovf_a[2]), 64'(1));
`ifdef MESH_EDGE_FIFO_STATS_EN
        check("t6_acc", 64'(acc_a[2*32 +: 32]), 64'(4));
        check("t6_drp", 64'(drp_a[2*16 +: 16]), 64'(2));
`endif
        reset = 1'b0;
        #2;
        for (int b = 0; b < 2; b++)
            for (int ch = 0; ch < NCH; ch++)
                sb[b][ch].delete();
        check("t6_rst_pndng", 64'(pndng_a), 64'(0));
        check("t6_rst_flags", 64'({ovf_a, udf_a, ovf_b, udf_b}), 64'(0));
        check("t6_rst_count", 64'(cnt_a), 64'(0));
`ifdef MESH_EDGE_FIFO_STATS_EN
        check("t6_rst_acc", 64'(acc_a[2*32 +: 32]), 64'(0));
        check("t6_rst_drp", 64'(drp_a[2*16 +: 16]), 64'(0));
`endif
        @(posedge clk);
        #1;
        reset = 1'b1;
        apply_stimulus(0, 2, 1, 0, W'(40'h77));
        check_output(0, 2, "t6_restart");

        $display("[TB] %0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
